mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data-RAM port between the processor (read/write) and the GPU
//  pixel reader (read-only). Fixed CPU priority; a GPU starvation guard is optional.
//  Sits between processor/chipSet and ramModule. Tags each read and routes its return
//  data to the requester. Reads are pipelined: one new access per cycle.
// PARAMETERS
//  ADDR_W        8    word-address width of the RAM port
//  DATA_W        32   data width
//  RD_LAT        1    RAM read latency in cycles (1..4)
//  STARVE_LIMIT  4    consecutive lost conflicts before the GPU is forced to win (1..15)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous reset, active-low
//  cpu_req     in   1       CPU access request; held with addr/we/wdata until cpu_gnt
//  cpu_we      in   1       1 = write, 0 = read
//  cpu_addr    in   ADDR_W  CPU word address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_gnt     out  1       access issued to RAM this cycle (combinational)
//  cpu_rvalid  out  1       cpu_rdata valid, single-cycle pulse
//  cpu_rdata   out  DATA_W  CPU read data
//  gpu_req     in   1       GPU read request; held with gpu_addr until gpu_gnt
//  gpu_addr    in   ADDR_W  GPU word address
//  gpu_gnt     out  1       GPU read issued this cycle (combinational)
//  gpu_rvalid  out  1       gpu_rdata valid, single-cycle pulse
//  gpu_rdata   out  DATA_W  GPU read data
//  mem_en      out  1       RAM access strobe
//  mem_we      out  1       RAM write enable
//  mem_addr    out  ADDR_W  RAM address
//  mem_wdata   out  DATA_W  RAM write data
//  mem_rdata   in   DATA_W  RAM read data, valid RD_LAT cycles after mem_en && !mem_we
// BEHAVIOUR
//  - Reset (rst=0, async): tag pipe cleared, starve_cnt=0, cpu_rvalid=gpu_rvalid=0,
//    rdata outputs=0. gnt/mem_* are combinational and follow req while in reset.
//  - Arbitration, same cycle: only cpu_req -> CPU; only gpu_req -> GPU;
//    both -> CPU unless the starve guard fires. At most one gnt per cycle.
//    mem_en = cpu_gnt|gpu_gnt; mem_addr/mem_we/mem_wdata come from the winner;
//    mem_we = cpu_we & cpu_gnt; mem_wdata = 0 when the GPU wins.
//  - Write completes at the granting edge and produces no rvalid.
//  - Read tag pipe: RD_LAT-deep shift register of {valid, owner}. The entry is pushed
//    on a granted read and shifts every cycle. At the output, rdata is registered
//    from mem_rdata and the owner's rvalid pulses one cycle after the tag exits:
//    total latency RD_LAT+1 from gnt to rvalid. Back-to-back reads from mixed owners
//    return in issue order. The non-owner rdata holds its last value.
//  - Tag FSM per slot: EMPTY -> CPU_RD | GPU_RD on a granted read -> EMPTY on shift-out.
//    Reads and writes interleave freely; there is no stall on a pending read.
//  - Starve counter (4 bit): +1 each cycle gpu_req && !gpu_gnt; cleared on gpu_gnt
//    or !gpu_req; saturates at 15.
//  - Reset mid-operation: in-flight tags are discarded and no rvalid is produced for them.
//    A requester must re-issue after reset.
//  - Requests with undefined addr are a requester error; the arbiter forwards them unchanged.
// CONFIGURATION
//  MEM_ARB_STARVE_EN defined: on a conflict with starve_cnt >= STARVE_LIMIT, the GPU wins.
//    CPU waits exactly that one cycle.
//  MEM_ARB_STARVE_EN undefined: strict CPU priority; the counter is not built and the
//    GPU is served only in cycles without cpu_req.
// TESTING
//  1 CPU write 0x12->addr 5, then CPU read 5 -> cpu_gnt both cycles;
//    cpu_rvalid 2 cycles after read gnt (RD_LAT=1) with 0x12.
//  2 GPU reads addr 0,1,2 back-to-back, no CPU -> gpu_gnt 3 cycles;
//    gpu_rvalid 3 consecutive cycles with data in order.
//  3 cpu_req & gpu_req held 10 cycles, CPU reads -> STARVE_EN off: GPU never granted.
//    STARVE_EN on, LIMIT=4: gpu_gnt in cycle 5, CPU resumes in cycle 6.
//  4 Interleave CPU rd A, GPU rd B, CPU wr C -> one rvalid each to CPU then GPU.
//    No rvalid for the write; mem_we only in cycle 3.
//  5 rst low one cycle after GPU read gnt -> gpu_rvalid never pulses; outputs 0.
//    starve_cnt 0.
//  6 RD_LAT=3 build, alternating CPU/GPU reads 8 cycles -> each rvalid 4 cycles after gnt.
//    Owner is correct for each.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: CPU port, GPU port and the RAM port.
// slave  : arbiter view (requests and RAM read data in, grants/returns/RAM strobes out)
// master : requester/RAM-side view
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              gpu_req;
    logic [ADDR_W-1:0] gpu_addr;
    logic              gpu_gnt;
    logic              gpu_rvalid;
    logic [DATA_W-1:0] gpu_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  gpu_req, gpu_addr,
        output gpu_gnt, gpu_rvalid, gpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output gpu_req, gpu_addr,
        input  gpu_gnt, gpu_rvalid, gpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-RAM port between the CPU (read/write) and the
// GPU pixel reader (read-only). Fixed CPU priority, one access per cycle, reads
// tagged with their owner and returned RD_LAT+1 cycles after the grant.
// Optional feature macro: MEM_ARB_STARVE_EN (GPU starvation guard).
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             rst,
    mem_port_arbiter_if.slave bus
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("RD_LAT must be 1..4");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be 1..15");
    end

    typedef enum logic [1:0] {
        TAG_EMPTY  = 2'd0,
        TAG_CPU_RD = 2'd1,
        TAG_GPU_RD = 2'd2
    } tag_e;

    logic              cpu_gnt_c;
    logic              gpu_gnt_c;
    logic              starve_win;
    logic [ADDR_W-1:0] addr_sel;

    tag_e              tag_q [RD_LAT];
    tag_e              tag_d [RD_LAT];

    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              gpu_rvalid_q, gpu_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] gpu_rdata_q, gpu_rdata_d;

`ifdef MEM_ARB_STARVE_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    // GPU is forced to win a conflict once it has lost STARVE_LIMIT in a row
    always_comb begin
        starve_win = bus.cpu_req && bus.gpu_req && (starve_cnt_q >= 4'(STARVE_LIMIT));
    end

    // Count consecutive cycles the GPU waits; clear on grant or idle, saturate at 15
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.gpu_req || gpu_gnt_c) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Strict CPU priority: the guard never fires
    always_comb begin
        starve_win = 1'b0;
    end
`endif

    // Arbitration and RAM port drive from the winner
    always_comb begin
        cpu_gnt_c     = bus.cpu_req && !starve_win;
        gpu_gnt_c     = bus.gpu_req && (!bus.cpu_req || starve_win);
        addr_sel      = cpu_gnt_c ? bus.cpu_addr : bus.gpu_addr;
        bus.cpu_gnt   = cpu_gnt_c;
        bus.gpu_gnt   = gpu_gnt_c;
        bus.mem_en    = cpu_gnt_c || gpu_gnt_c;
        bus.mem_we    = bus.cpu_we && cpu_gnt_c;
        bus.mem_addr  = addr_sel;
        bus.mem_wdata = cpu_gnt_c ? bus.cpu_wdata : '0;
    end

    // Tag pipe: push the owner of a granted read, shift one slot per cycle
    always_comb begin
        tag_d[0] = TAG_EMPTY;
        if (cpu_gnt_c && !bus.cpu_we) begin
            tag_d[0] = TAG_CPU_RD;
        end else if (gpu_gnt_c) begin
            tag_d[0] = TAG_GPU_RD;
        end
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Return stage: the exiting tag selects which requester captures mem_rdata
    always_comb begin
        cpu_rvalid_d = (tag_q[RD_LAT-1] == TAG_CPU_RD);
        gpu_rvalid_d = (tag_q[RD_LAT-1] == TAG_GPU_RD);
        cpu_rdata_d  = cpu_rvalid_d ? bus.mem_rdata : cpu_rdata_q;
        gpu_rdata_d  = gpu_rvalid_d ? bus.mem_rdata : gpu_rdata_q;
    end

    // Tag pipe and return registers; reset discards in-flight reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= TAG_EMPTY;
            end
            cpu_rvalid_q <= 1'b0;
            gpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            gpu_rdata_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
            cpu_rvalid_q <= cpu_rvalid_d;
            gpu_rvalid_q <= gpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            gpu_rdata_q  <= gpu_rdata_d;
        end
    end

    // Drive registered return outputs
    always_comb begin
        bus.cpu_rvalid = cpu_rvalid_q;
        bus.gpu_rvalid = gpu_rvalid_q;
        bus.cpu_rdata  = cpu_rdata_q;
        bus.gpu_rdata  = gpu_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vectors with hand-computed grants and
// read data; a scoreboard queue holds expected returns, a monitor pops and compares.
// RAM model: unwritten word at address a reads as 32'hA5A5_0000 + a.
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 32;
    localparam int RD_LAT       = 1;
    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic        owner;   // 0 = CPU, 1 = GPU
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int          checks;
    int          errors;
    int          rv_count;
    int          rv_mark;
    logic [31:0] last_cpu;
    logic [31:0] last_gpu;
    exp_t        sb [$];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RD_LAT      (RD_LAT),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with RD_LAT-cycle read pipeline
    logic [31:0]  ram [256];
    logic [255:0] written;
    logic [31:0]  rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (!rst) begin
            written <= '0;
        end else if (bus.mem_en && bus.mem_we) begin
            ram[bus.mem_addr]     <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
        end
        rd_pipe[0] <= written[bus.mem_addr] ? ram[bus.mem_addr]
                                            : (32'hA5A5_0000 + 32'(bus.mem_addr));
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus with the hand-computed grant outcome and read data
    task automatic step(input logic creq, input logic cwe, input logic [7:0] caddr,
                        input logic [31:0] cwdata, input logic greq, input logic [7:0] gaddr,
                        input logic ecg, input logic egg, input logic [31:0] erd);
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwdata;
        bus.gpu_req   = greq;
        bus.gpu_addr  = gaddr;
        @(negedge clk);
        chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(ecg));
        chk("gpu_gnt", 32'(bus.gpu_gnt), 32'(egg));
        chk("mem_en", 32'(bus.mem_en), 32'(ecg | egg));
        chk("mem_we", 32'(bus.mem_we), 32'(cwe & ecg));
        if (ecg | egg) chk("mem_addr", 32'(bus.mem_addr), 32'(ecg ? caddr : gaddr));
        if (ecg & cwe) chk("mem_wdata", bus.mem_wdata, cwdata);
        if (egg)       chk("mem_wdata_gpu", bus.mem_wdata, 32'h0);
        if (ecg && !cwe) sb.push_back('{1'b0, erd, cyc + RD_LAT + 1});
        if (egg)         sb.push_back('{1'b1, erd, cyc + RD_LAT + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h0, 32'h0, 0, 8'h0, 0, 0, 32'h0);
    endtask

    // Monitor: every rvalid pops the oldest expected return
    always @(negedge clk) begin
        if (bus.cpu_rvalid || bus.gpu_rvalid) begin
            rv_count++;
            if (bus.cpu_rvalid && bus.gpu_rvalid) begin
                checks++;
                errors++;
                $display("FAIL both_rvalid actual=1/1 expected one owner (cycle %0d)", cyc);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid cpu=%0b gpu=%0b expected none (cycle %0d)",
                         bus.cpu_rvalid, bus.gpu_rvalid, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rvalid_owner", 32'(bus.gpu_rvalid), 32'(e.owner));
                chk("rvalid_cycle", cyc, e.cyc);
                if (e.owner) begin
                    chk("gpu_rdata", bus.gpu_rdata, e.data);
                    chk("cpu_rdata_hold", bus.cpu_rdata, last_cpu);
                    last_gpu = e.data;
                end else begin
                    chk("cpu_rdata", bus.cpu_rdata, e.data);
                    chk("gpu_rdata_hold", bus.gpu_rdata, last_gpu);
                    last_cpu = e.data;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic eg;
        cyc = 0; checks = 0; errors = 0; rv_count = 0; rv_mark = 0;
        last_cpu = 32'h0; last_gpu = 32'h0;
        rst = 1'b0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.gpu_req = 0; bus.gpu_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        chk("rst_gpu_rvalid", 32'(bus.gpu_rvalid), 32'h0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rst_gpu_rdata", bus.gpu_rdata, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: CPU write 0x12 -> 5, then read 5
        step(1, 1, 8'h05, 32'h12, 0, 8'h0, 1, 0, 32'h0);
        step(1, 0, 8'h05, 32'h0,  0, 8'h0, 1, 0, 32'h12);
        idle(3);

        // 2: GPU back-to-back reads 0,1,2
        step(0, 0, 8'h0, 32'h0, 1, 8'h00, 0, 1, 32'hA5A5_0000);
        step(0, 0, 8'h0, 32'h0, 1, 8'h01, 0, 1, 32'hA5A5_0001);
        step(0, 0, 8'h0, 32'h0, 1, 8'h02, 0, 1, 32'hA5A5_0002);
        idle(3);

        // 3: both request for 10 cycles; CPU reads 0x0A+k, GPU reads 0x20
        for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_STARVE_EN
            eg = (k == 4) || (k == 9);
`else
            eg = 1'b0;
`endif
            step(1, 0, 8'(32'h0A + k), 32'h0, 1, 8'h20, !eg, eg,
                 eg ? 32'hA5A5_0020 : (32'hA5A5_000A + 32'(k)));
        end
        idle(3);

        // 4: CPU rd 0x30, GPU rd 0x31, CPU wr 0x32
        step(1, 0, 8'h30, 32'h0,        0, 8'h0,  1, 0, 32'hA5A5_0030);
        step(0, 0, 8'h0,  32'h0,        1, 8'h31, 0, 1, 32'hA5A5_0031);
        step(1, 1, 8'h32, 32'hDEAD_BEEF, 0, 8'h0, 1, 0, 32'h0);
        idle(3);

        // 5: reset one cycle after a GPU read grant; the read is discarded
        step(0, 0, 8'h0, 32'h0, 1, 8'h40, 0, 1, 32'hA5A5_0040);
        bus.gpu_req = 0;
        rst = 1'b0;
        @(negedge clk);
        sb.delete();
        rv_mark = rv_count;
        last_cpu = 32'h0;
        last_gpu = 32'h0;
        chk("rst5_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        chk("rst5_gpu_rvalid", 32'(bus.gpu_rvalid), 32'h0);
        chk("rst5_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rst5_gpu_rdata", bus.gpu_rdata, 32'h0);
`ifdef MEM_ARB_STARVE_EN
        chk("rst5_starve_cnt", 32'(dut.starve_cnt_q), 32'h0);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle(RD_LAT + 4);
        chk("rst5_no_rvalid", 32'(rv_count - rv_mark), 32'h0);

        // 6: alternating CPU/GPU reads for 8 cycles
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0)
                step(1, 0, 8'(32'h50 + k), 32'h0, 0, 8'h0, 1, 0, 32'hA5A5_0050 + 32'(k));
            else
                step(0, 0, 8'h0, 32'h0, 1, 8'(32'h50 + k), 0, 1, 32'hA5A5_0050 + 32'(k));
        end
        idle(RD_LAT + 3);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
